// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the flash-to-SRAM loader.
package flash_loader_pkg;
  localparam int ADR_W  = 17;   // SRAM word address width
  localparam int DAT_W  = 16;   // SRAM word width
  localparam int FADR_W = 24;   // SPI flash byte address width
  localparam int WCNT_W = 18;   // word counter, holds up to 131072
  localparam int BCNT_W = 6;    // SPI bit counter

  localparam logic [7:0] READ_OP = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_WRITE, ST_DONE
  } state_t;
endpackage

// File: rtl/flash_loader_spi_bit_engine.sv
// SPI mode-0 bit engine: two clk_vga cycles per bit, command/address
// shift-out, data shift-in and a free-running bit counter.
module spi_bit_engine
  import flash_loader_pkg::*;
#(
  parameter logic [FADR_W-1:0] FLASH_BASE = 24'h100000
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              i_load,     // start of a transaction
  input  logic              i_run,      // clock bits; low pauses with sck low
  input  logic              i_miso,
  output logic              o_sck,
  output logic              o_mosi,
  output logic              o_bit_end,  // this edge completes a bit
  output logic [BCNT_W-1:0] o_bit_cnt,
  output logic [DAT_W-1:0]  o_rx_next   // rx word including the bit sampled now
);
  logic              r_ph;
  logic              r_sck;
  logic [31:0]       r_tx;
  logic [DAT_W-1:0]  r_rx;
  logic [BCNT_W-1:0] r_cnt;

  assign o_sck     = r_sck;
  assign o_mosi    = r_tx[31];
  assign o_bit_end = i_run & r_ph;
  assign o_bit_cnt = r_cnt;
  assign o_rx_next = {r_rx[DAT_W-2:0], i_miso};

  // Phase toggle; at the end of phase 1 sample miso, shift mosi, count the bit.
  // Zeros shift into r_tx, so mosi is 0 once command and address are out.
  // The counter wraps at 64; being a multiple of 16, data words still end
  // on cnt[3:0]==15.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_ph  <= 1'b0;
      r_sck <= 1'b0;
      r_tx  <= '0;
      r_rx  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_ph  <= 1'b0;
      r_sck <= 1'b0;
      r_tx  <= {READ_OP, FLASH_BASE};
      r_cnt <= '0;
    end else if (i_run) begin
      if (!r_ph) begin
        r_ph  <= 1'b1;
        r_sck <= 1'b1;
      end else begin
        r_ph  <= 1'b0;
        r_sck <= 1'b0;
        r_rx  <= o_rx_next;
        r_tx  <= {r_tx[30:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_ph  <= 1'b0;
      r_sck <= 1'b0;
    end
  end
endmodule

// File: rtl/flash_loader.sv
// Copies WORD_COUNT 16-bit words from SPI flash (single READ transaction)
// into SRAM through a req/ack write port.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter logic [FADR_W-1:0] FLASH_BASE = 24'h100000,
  parameter int                WORD_COUNT = 65536,
  parameter logic [ADR_W-1:0]  SRAM_BASE  = 17'h00000
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             flash_ss,
  output logic             flash_sck,
  output logic             flash_mosi,
  input  logic             flash_miso,
  output logic             wr_req,
  output logic [ADR_W-1:0] wr_adr,
  output logic [DAT_W-1:0] wr_dat,
  input  logic             wr_ack
);
  localparam logic [WCNT_W-1:0] WC = WCNT_W'(WORD_COUNT);

  state_t            r_state;
  logic              r_ss, r_busy, r_done, r_wr_req;
  logic [ADR_W-1:0]  r_wr_adr;
  logic [DAT_W-1:0]  r_wr_dat;
  logic [WCNT_W-1:0] r_words;

  logic              w_accept, w_run, w_bit_end;
  logic [BCNT_W-1:0] w_bit_cnt;
  logic [DAT_W-1:0]  w_rx_next;
  logic [WCNT_W-1:0] w_words_nxt;

  assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_run       = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_words_nxt = r_words + 1'b1;

  assign busy     = r_busy;
  assign done     = r_done;
  assign flash_ss = r_ss;
  assign wr_req   = r_wr_req;
  assign wr_adr   = r_wr_adr;
  assign wr_dat   = r_wr_dat;

  spi_bit_engine #(.FLASH_BASE(FLASH_BASE)) u_eng (
    .clk_vga   (clk_vga),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_run     (w_run),
    .i_miso    (flash_miso),
    .o_sck     (flash_sck),
    .o_mosi    (flash_mosi),
    .o_bit_end (w_bit_end),
    .o_bit_cnt (w_bit_cnt),
    .o_rx_next (w_rx_next)
  );

  // Sequencer: cmd (bits 0-7), addr (8-31), then 16-bit data words, each
  // followed by a write with the SPI clock paused.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ss     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_req <= 1'b0;
      r_wr_adr <= SRAM_BASE;
      r_wr_dat <= '0;
      r_words  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) begin
          r_state  <= ST_CMD;
          r_ss     <= 1'b0;
          r_busy   <= 1'b1;
          r_done   <= 1'b0;
          r_wr_adr <= SRAM_BASE;
          r_words  <= '0;
        end
        ST_CMD:  if (w_bit_end && w_bit_cnt == 6'd7)  r_state <= ST_ADDR;
        ST_ADDR: if (w_bit_end && w_bit_cnt == 6'd31) r_state <= ST_DATA;
        ST_DATA: if (w_bit_end && w_bit_cnt[3:0] == 4'hF) begin
          r_state  <= ST_WRITE;
          r_wr_req <= 1'b1;
          r_wr_dat <= w_rx_next;
        end
        ST_WRITE: if (wr_ack) begin
          r_wr_req <= 1'b0;
          r_wr_adr <= r_wr_adr + 1'b1;
          r_words  <= w_words_nxt;
          if (w_words_nxt == WC) begin
            r_state <= ST_DONE;
            r_ss    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_DATA;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: flash model, configurable ack model, write scoreboard.
module tb_flash_loader;
  localparam int WC = 2;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, flash_ss, flash_sck, flash_mosi;
  logic        flash_miso = 1'b0;
  logic        wr_req;
  logic [16:0] wr_adr;
  logic [15:0] wr_dat;
  logic        wr_ack;

  flash_loader #(.FLASH_BASE(24'h100000), .WORD_COUNT(WC), .SRAM_BASE(17'h00000)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .flash_ss(flash_ss), .flash_sck(flash_sck), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .wr_req(wr_req), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .wr_ack(wr_ack)
  );

  always #5 clk_vga = ~clk_vga;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Flash model: records the first 32 mosi bits, then serves bytes 12 34 56 78.
  logic [7:0]  fdata [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  int          rise_cnt = 0;
  logic [31:0] mosi_cap = '0;

  always @(posedge flash_sck or posedge flash_ss) begin
    if (flash_ss) rise_cnt = 0;
    else begin
      if (rise_cnt < 32) mosi_cap = {mosi_cap[30:0], flash_mosi};
      rise_cnt++;
    end
  end

  // Next data bit is presented after the falling edge, ahead of the next rise.
  always @(negedge flash_sck) begin
    int k;
    logic [7:0] b;
    if (!flash_ss && rise_cnt >= 32) begin
      k = rise_cnt - 32;
      b = fdata[(k / 8) % 4];
      flash_miso = b[7 - (k % 8)];
    end
  end

  // Ack model: mode 0 acks dly cycles after wr_req rises (0 = same cycle);
  // mode 1 holds ack high permanently.
  int ack_mode = 0;
  int ack_dly  = 1;
  int wcnt     = 0;
  always @(posedge clk_vga) wcnt <= (wr_req && !wr_ack) ? wcnt + 1 : 0;
  assign wr_ack = (ack_mode == 1) ? 1'b1 : (wr_req && (wcnt >= ack_dly));

  // Scoreboard and write monitor
  typedef struct packed { logic [16:0] adr; logic [15:0] dat; } wr_t;
  wr_t sb_q[$];
  int  nwr = 0, pause_err = 0;
  bit  req_seen = 0;

  always @(negedge clk_vga) begin
    wr_t e;
    if (rst_n && wr_req) begin
      req_seen = 1;
      if (flash_sck || flash_ss) pause_err++;
      if (wr_ack) begin
        nwr++;
        if (sb_q.size() == 0) chk("unexpected_write", 32'(wr_adr), 32'hFFFFFFFF);
        else begin
          e = sb_q.pop_front();
          chk("wr_adr", 32'(wr_adr), 32'(e.adr));
          chk("wr_dat", 32'(wr_dat), 32'(e.dat));
        end
      end
    end
  end

  logic [15:0] exp_word [WC] = '{16'h1234, 16'h5678};

  task automatic run_copy(input int mode, input int dly, input int glitch, input int lat);
    int n;
    ack_mode = mode; ack_dly = dly;
    nwr = 0; pause_err = 0; req_seen = 0;
    for (int w = 0; w < WC; w++) sb_q.push_back({17'(w), exp_word[w]});
    @(negedge clk_vga); start = 1'b1;
    @(negedge clk_vga); start = 1'b0;
    n = 1;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done_clr", 32'(done), 32'd0);
    chk("accept_ss", 32'(flash_ss), 32'd0);
    while (!wr_req && n < 400) begin
      @(negedge clk_vga); n++;
      start = (glitch != 0 && n == glitch);
    end
    start = 1'b0;
    chk("first_req_latency", 32'(n), 32'(lat));
    while (!done && n < 3000) begin @(negedge clk_vga); n++; end
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("ss_end", 32'(flash_ss), 32'd1);
    chk("mosi_cmd_addr", mosi_cap, 32'h03100000);
    chk("write_count", 32'(nwr), 32'(WC));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("pause_sck_ss", 32'(pause_err), 32'd0);
  endtask

  typedef struct { int mode; int dly; int glitch; int lat; } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 1,  0, 97};  // registered ack
    vecs[1] = '{0, 20, 0, 97};  // long ack wait
    vecs[2] = '{0, 0,  0, 97};  // ack in the same cycle as wr_req
    vecs[3] = '{1, 0,  0, 97};  // ack stuck high, also while wr_req low
    vecs[4] = '{0, 1, 30, 97};  // start pulsed mid-copy

    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga);
    chk("rst_ss", 32'(flash_ss), 32'd1);
    chk("rst_sck", 32'(flash_sck), 32'd0);
    chk("rst_mosi", 32'(flash_mosi), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_adr", 32'(wr_adr), 32'd0);
    chk("rst_wr_dat", 32'(wr_dat), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_copy(vecs[i].mode, vecs[i].dly, vecs[i].glitch, vecs[i].lat);

    // Abort: reset 50 cycles into a copy.
    ack_mode = 0; ack_dly = 1; req_seen = 0;
    @(negedge clk_vga); start = 1'b1;
    @(negedge clk_vga); start = 1'b0;
    repeat (49) @(negedge clk_vga);
    rst_n = 1'b0;
    @(negedge clk_vga);
    chk("abort_ss", 32'(flash_ss), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sck", 32'(flash_sck), 32'd0);
    chk("abort_wr_req", 32'(wr_req), 32'd0);
    chk("abort_no_write", 32'(req_seen), 32'd0);
    rst_n = 1'b1;
    run_copy(0, 1, 0, 97);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter FLASH_BASE, default 24'h100000, byte address in SPI flash of the first word to copy.
REQ-002 Parameter WORD_COUNT, default 65536, number of 16-bit words copied into SRAM; legal range 1..131072.
REQ-003 Parameter SRAM_BASE, default 17'h00000, first SRAM word address written.
REQ-004 clk_vga  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  level; sampled high in IDLE or DONE begins a copy.
REQ-007 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-008 done  output  1  high in DONE; cleared when the next start is accepted.
REQ-009 flash_ss  output  1  SPI chip select, active low.
REQ-010 flash_sck  output  1  SPI clock, mode 0, idle low.
REQ-011 flash_mosi  output  1  SPI data to flash.
REQ-012 flash_miso  input  1  SPI data from flash.
REQ-013 wr_req  output  1  SRAM write request toward the video-memory port.
REQ-014 wr_adr  output  17  SRAM word address, valid while wr_req is high.
REQ-015 wr_dat  output  16  SRAM write data, valid while wr_req is high.
REQ-016 wr_ack  input  1  write accepted; may arrive any number of cycles after wr_req, including the same cycle.

Function
REQ-017 States: IDLE, CMD, ADDR, DATA, WRITE, DONE.
REQ-018 IDLE/DONE + start=1 -> CMD next cycle, with flash_ss low and busy high.
REQ-019 Bit timing: each SPI bit takes 2 cycles; phase 0 drives sck low with mosi updated, phase 1 drives sck high.
REQ-020 flash_miso is sampled at the clk_vga edge that ends phase 1.
REQ-021 CMD shifts 8'h03 MSB first (16 cycles), then goes to ADDR.
REQ-022 ADDR shifts FLASH_BASE MSB first (48 cycles), then goes to DATA; mosi is 0 during DATA.
REQ-023 DATA shifts in 16 bits (32 cycles), big-endian: first byte received forms wr_dat[15:8].
REQ-024 DATA -> WRITE: wr_req goes high with stable wr_adr/wr_dat, and sck is held low with ss still low (clock paused).
REQ-025 wr_ack sampled high while wr_req is high completes the write; wr_req is low the next cycle.
REQ-026 After a completed write: wr_adr increments by 1 and word counter increments.
REQ-027 After a completed write, if the counter < WORD_COUNT -> DATA (same SPI transaction continues); otherwise -> DONE.
REQ-028 On entering DONE: flash_ss high, busy low, done high.
REQ-029 wr_adr starts at SRAM_BASE; SRAM_BASE + WORD_COUNT must not exceed 131072, so no wrap occurs.
REQ-030 start while busy is ignored.
REQ-031 wr_ack while wr_req is low is ignored.
REQ-032 Nominal latency per word = 32 cycles + ack wait; first wr_req occurs 1+16+48+32 = 97 cycles after start is sampled.

Reset
REQ-033 rst_n low at any edge forces IDLE: flash_ss=1, flash_sck=0, flash_mosi=0, wr_req=0, wr_adr=SRAM_BASE, wr_dat=0, busy=0, done=0, counters=0.
REQ-034 Reset mid-transfer aborts the copy without a final write; ss rises in the same cycle reset is sampled.

Structure
REQ-035 A shared package holds the state enum, the READ opcode constant 8'h03, and address/data width constants (17, 16, 24).
REQ-036 One sub-module, spi_bit_engine, owns sck phase, the shift registers and the bit counter.
REQ-037 Estimated size: 150-300 RTL lines.

Verification
REQ-038 Reset then start, WORD_COUNT=2, flash model returning 12 34 56 78, wr_ack registered 1 cycle after wr_req -> writes (0x00000, 0x1234) then (0x00001, 0x5678); done high; ss high.
REQ-039 Capture mosi on sck rising edges -> 0x03, 0x10, 0x00, 0x00.
REQ-040 wr_ack delayed 20 cycles -> sck stays low and ss stays low for the whole wait; the next word is intact.
REQ-041 rst_n low at cycle 50 after start -> next cycle ss=1, busy=0, wr_req never asserted; a fresh start then completes normally.
REQ-042 start pulsed again at cycle 30 of a copy -> no effect; second start after done -> done clears and the copy repeats identically.
REQ-043 wr_ack high in the same cycle wr_req rises -> wr_req low next cycle; exactly one write per word.
